// File: rtl/picomips_io_pkg.sv
// Shared types and constants for the picoMIPS switch/LED operand port.
package picomips_io_pkg;

    // Operand-capture FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HOLD    = 2'd2
    } sw_state_t;

    // Names of the in_index values, in the order the core expects the operands.
    localparam int OP_RE_W = 0;
    localparam int OP_IM_W = 1;
    localparam int OP_RE_B = 2;
    localparam int OP_IM_B = 3;
    localparam int OP_RE_A = 4;
    localparam int OP_IM_A = 5;

endpackage

// File: rtl/sw_debounce.sv
// Synchroniser and debounce filter for the press switch.
// deb_o only follows the synchronised level once that level has been
// stable for DEBOUNCE_CYCLES consecutive samples.
module sw_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic strobe_i,
    output logic deb_o
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   level;
    logic                   changed;

    assign level   = sync_q[SYNC_STAGES-1];
    assign changed = (level != sync_prev_q);

    // Count consecutive equal samples; accept the level when the count saturates.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (!changed && (cnt_d == CNT_MAX)) begin
            deb_d = level;
        end
    end

    // Synchroniser chain, previous-sample register, counter and debounced level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            cnt_q       <= '0;
            // The debounced level starts as "pressed": a switch held through
            // reset must be seen released before a press can count.
            deb_q       <= 1'b1;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            sync_q[0] <= strobe_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_prev_q <= level;
            cnt_q       <= cnt_d;
            deb_q       <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/picomips_switch_port.sv
// Responder end of the board switch/LED operand protocol for picoMIPS4test.
// Captures the switch byte on a debounced release, offers it to the core via
// valid/ready with an operand index, and holds the core's result on LED.
module picomips_switch_port
    import picomips_io_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int N_OPERANDS      = 6
) (
    input  logic                          fastclk,
    input  logic                          n_reset,
    input  logic [DATA_W-1:0]             sw_data,
    input  logic                          sw_strobe,
    output logic [DATA_W-1:0]             in_data,
    output logic                          in_valid,
    input  logic                          in_ready,
    output logic [$clog2(N_OPERANDS)-1:0] in_index,
    output logic                          overrun,
    input  logic                          led_we,
    input  logic [DATA_W-1:0]             led_data,
    output logic [DATA_W-1:0]             LED
);

    localparam int               IDX_W    = $clog2(N_OPERANDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPERANDS - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(OP_RE_W);

    logic                           deb, deb_prev_q, deb_rise, deb_fall;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q;
    sw_state_t                      state_q, state_d;
    logic [DATA_W-1:0]              in_data_q, in_data_d;
    logic                           in_valid_q, in_valid_d;
    logic [IDX_W-1:0]               in_index_q, in_index_d;
    logic                           overrun_q, overrun_d;
    logic [DATA_W-1:0]              led_q;
    logic                           handshake, capture, drop;

    sw_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i    (fastclk),
        .rst_n_i  (n_reset),
        .strobe_i (sw_strobe),
        .deb_o    (deb)
    );

    assign deb_rise  = deb & ~deb_prev_q;
    assign deb_fall  = ~deb & deb_prev_q;
    assign handshake = in_valid_q & in_ready;

    // Synchronise the data byte alongside the strobe and remember the last debounced level.
    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            // NOTE: the synchroniser is a plain register chain, not a memory,
            // so it is cleared by reset like any other control state.
            data_sync_q <= '0;
            deb_prev_q  <= 1'b1;
        end else begin
            data_sync_q[0] <= sw_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= data_sync_q[i-1];
            end
            deb_prev_q <= deb;
        end
    end

    // FSM state register.
    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: follow press/release of the debounced strobe and the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (deb_rise) state_d = PRESSED;
            PRESSED: if (deb_fall) state_d = HOLD;
            HOLD: begin
                if (deb_rise) begin
                    state_d = PRESSED;
                end else if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: on release, capture if the slot is free or being emptied, else drop.
    always_comb begin
        capture = 1'b0;
        drop    = 1'b0;
        if ((state_q == PRESSED) && deb_fall) begin
            if (in_valid_q && !in_ready) begin
                drop = 1'b1;
            end else begin
                capture = 1'b1;
            end
        end
    end

    // Operand slot next state: handshake empties it, capture refills it in the same cycle.
    always_comb begin
        in_data_d  = in_data_q;
        in_valid_d = in_valid_q;
        in_index_d = in_index_q;
        overrun_d  = overrun_q;
        if (handshake) begin
            in_valid_d = 1'b0;
            in_index_d = (in_index_q == IDX_LAST) ? IDX_FIRST : in_index_q + IDX_W'(1);
        end
        if (capture) begin
            in_data_d  = data_sync_q[SYNC_STAGES-1];
            in_valid_d = 1'b1;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    // Operand slot registers.
    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
            in_index_q <= IDX_FIRST;
            overrun_q  <= 1'b0;
        end else begin
            in_data_q  <= in_data_d;
            in_valid_q <= in_valid_d;
            in_index_q <= in_index_d;
            overrun_q  <= overrun_d;
        end
    end

    // LED register, written by the core independently of the operand path.
    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            led_q <= '0;
        end else if (led_we) begin
            led_q <= led_data;
        end
    end

    assign in_data  = in_data_q;
    assign in_valid = in_valid_q;
    assign in_index = in_index_q;
    assign overrun  = overrun_q;
    assign LED      = led_q;

endmodule

// File: tb/tb_picomips_switch_port.sv
// Self-checking bench for picomips_switch_port: directed table/sequence tests
// followed by randomized press/release traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_picomips_switch_port;
    import picomips_io_pkg::*;

    localparam int DATA_W     = 8;
    localparam int N_OPERANDS = 6;
    localparam int LAT        = 7;   // release edge to in_valid edge

    logic              fastclk;
    logic              n_reset;
    logic [DATA_W-1:0] sw_data;
    logic              sw_strobe;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_index;
    logic              overrun;
    logic              led_we;
    logic [DATA_W-1:0] led_data;
    logic [DATA_W-1:0] LED;

    picomips_switch_port u_dut (
        .fastclk   (fastclk),
        .n_reset   (n_reset),
        .sw_data   (sw_data),
        .sw_strobe (sw_strobe),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .overrun   (overrun),
        .led_we    (led_we),
        .led_data  (led_data),
        .LED       (LED)
    );

    initial fastclk = 1'b0;
    always #5 fastclk = ~fastclk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic [2:0] exp_index;
    } vec_t;

    typedef struct {
        int         at;
        logic [7:0] data;
    } arr_t;

    vec_t       vecs[7];
    arr_t       arrivals[$];
    arr_t       a;
    int         lat, first, vcnt, seen, rem;
    logic       level, hs, v0;
    logic [7:0] cur_data;
    logic       m_valid, m_over;
    logic [2:0] m_idx;
    logic [7:0] m_data, m_led;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fastclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        n_reset   = 1'b0;
        sw_strobe = 1'b0;
        in_ready  = 1'b0;
        led_we    = 1'b0;
        ticks(3);
        n_reset = 1'b1;
        ticks(10);
    endtask

    task automatic press_release(input logic [7:0] d, input int len);
        sw_data   = d;
        sw_strobe = 1'b1;
        ticks(len);
        sw_strobe = 1'b0;
    endtask

    // Returns the number of edges after release at which in_valid was first seen.
    task automatic wait_valid(input string name, output int l);
        l = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (in_valid) begin
                l = k;
                break;
            end
        end
        checks++;
        if (l < 0) begin
            failures++;
            $display("FAIL %s: in_valid never rose within 20 cycles", name);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h40, 3'd0};
        vecs[1] = '{8'hC0, 3'd1};
        vecs[2] = '{8'h0A, 3'd2};
        vecs[3] = '{8'h04, 3'd3};
        vecs[4] = '{8'h01, 3'd4};
        vecs[5] = '{8'h08, 3'd5};
        vecs[6] = '{8'h11, 3'd0};

        sw_data = '0; sw_strobe = 0; in_ready = 0; led_we = 0; led_data = '0;

        // Reset state
        n_reset = 1'b0;
        ticks(2);
        check("rst_in_data",  in_data,  0);
        check("rst_in_valid", in_valid, 0);
        check("rst_in_index", in_index, 0);
        check("rst_overrun",  overrun,  0);
        check("rst_led",      LED,      0);
        n_reset = 1'b1;
        ticks(10);

        // 1: latency and single-cycle valid with in_ready=1
        in_ready = 1'b1;
        press_release(8'h40, 10);
        first = -1; vcnt = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (in_valid) begin
                vcnt++;
                if (first < 0) begin
                    first = k;
                    check("t1_data",  in_data,  8'h40);
                    check("t1_index", in_index, 0);
                end
            end
        end
        check("t1_latency", first, LAT);
        check("t1_valid_cycles", vcnt, 1);

        // 2: data changing while pressed, value at release wins
        sw_data = 8'h0A; sw_strobe = 1'b1;
        ticks(5);
        sw_data = 8'h04;
        ticks(5);
        sw_strobe = 1'b0;
        wait_valid("t2_valid", lat);
        check("t2_data",  in_data,  8'h04);
        check("t2_index", in_index, 1);
        tick();
        check("t2_valid_low", in_valid, 0);
        ticks(4);

        // 3: short glitches rejected
        sw_strobe = 1'b1; ticks(2); sw_strobe = 1'b0; ticks(6);
        sw_strobe = 1'b1; ticks(3); sw_strobe = 1'b0;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (in_valid) seen = 1;
        end
        check("t3_no_valid", seen, 0);
        check("t3_index", in_index, 2);
        check("t3_state", u_dut.state_q, IDLE);

        // 4: operand index sequence and wrap
        do_reset();
        in_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            press_release(vecs[i].data, 8);
            wait_valid($sformatf("t4_valid_%0d", i), lat);
            check($sformatf("t4_data_%0d", i),  in_data,  vecs[i].data);
            check($sformatf("t4_index_%0d", i), in_index, vecs[i].exp_index);
            ticks(4);
        end

        // 5: release while not accepted -> overrun, old byte kept
        do_reset();
        press_release(8'h0A, 8);
        wait_valid("t5_valid", lat);
        check("t5_first_data", in_data, 8'h0A);
        ticks(3);
        press_release(8'h04, 8);
        ticks(12);
        check("t5_data_kept", in_data,  8'h0A);
        check("t5_valid_held", in_valid, 1);
        check("t5_overrun",   overrun,  1);
        check("t5_index",     in_index, 0);
        in_ready = 1'b1;
        tick();
        check("t5_hs_valid", in_valid, 0);
        check("t5_hs_index", in_index, 1);
        check("t5_overrun_sticky", overrun, 1);

        // 6: reset while pressed, strobe held through reset
        led_we = 1'b1; led_data = 8'hC3;
        tick();
        check("t6_led_pre", LED, 8'hC3);
        sw_data = 8'h77; sw_strobe = 1'b1;
        ticks(10);
        led_data = 8'h5A;
        n_reset  = 1'b0;
        #1;
        check("t6_rst_data",    in_data,  0);
        check("t6_rst_valid",   in_valid, 0);
        check("t6_rst_index",   in_index, 0);
        check("t6_rst_overrun", overrun,  0);
        check("t6_rst_led",     LED,      0);
        ticks(2);
        check("t6_rst_led_held", LED, 0);
        led_we  = 1'b0;
        n_reset = 1'b1;
        ticks(10);
        sw_strobe = 1'b0;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (in_valid) seen = 1;
        end
        check("t6_no_stale_operand", seen, 0);
        press_release(8'h33, 8);
        wait_valid("t6_fresh_valid", lat);
        check("t6_fresh_data",  in_data,  8'h33);
        check("t6_fresh_index", in_index, 0);
        led_we = 1'b1; led_data = 8'h5A;
        tick();
        check("t6_led_write", LED, 8'h5A);
        led_we = 1'b0; led_data = 8'hFF;
        tick();
        check("t6_led_hold", LED, 8'h5A);

        // Randomized traffic against a transaction-level model: every release
        // produces an operand arrival LAT edges later, which fills an empty
        // slot (or one being handshaken) or sets overrun otherwise.
        do_reset();
        m_valid = 0; m_over = 0; m_idx = 0; m_data = 0; m_led = 0;
        arrivals.delete();
        level = 1'b0; rem = 10; cur_data = 8'h00;
        for (int e = 0; e < 900; e++) begin
            if (rem == 0) begin
                level = ~level;
                rem   = $urandom_range(6, 12);
                if (level) cur_data = 8'($urandom);
                else       arrivals.push_back('{e + LAT, cur_data});
            end
            rem--;
            sw_strobe = level;
            sw_data   = cur_data;
            in_ready  = ($urandom_range(0, 3) != 0);
            led_we    = ($urandom_range(0, 4) == 0);
            led_data  = 8'($urandom);
            @(posedge fastclk);
            v0 = m_valid;
            hs = m_valid && in_ready;
            if (hs) begin
                m_valid = 1'b0;
                m_idx   = 3'((int'(m_idx) + 1) % N_OPERANDS);
            end
            if (arrivals.size() > 0 && arrivals[0].at == e) begin
                a = arrivals.pop_front();
                if (v0 && !in_ready) begin
                    m_over = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_data  = a.data;
                end
            end
            if (led_we) m_led = led_data;
            #1;
            check($sformatf("rand_cycle_%0d {valid,overrun,index,data,led}", e),
                  {11'd0, in_valid, overrun, in_index, in_data, LED},
                  {11'd0, m_valid, m_over, m_idx, m_data, m_led});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
